// File: rtl/rng_pkg.sv
// Shared types and helpers for the multi-channel RNG controller.
// Holds the source-mode and overflow-policy encodings plus the bytes-per-word helper.
package rng_pkg;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_XOR    = 1'b1
    } mode_e;

    typedef enum logic {
        OVF_HALT = 1'b0,
        OVF_DROP = 1'b1
    } ovf_e;

    localparam int DROP_W = 16;

    function automatic int bpw(input int word_w);
        return word_w / 8;
    endfunction

endpackage

// File: rtl/rng_ctrl_mc_if.sv
// Sample-input / FIFO-output bus of the RNG controller.
// The master side feeds samples and FIFO status; the slave side is the controller.
interface rng_ctrl_mc_if #(
    parameter int NCH      = 4,
    parameter int SAMPLE_W = 16,
    parameter int WORD_W   = 32
);
    logic [NCH*SAMPLE_W-1:0] DATA_IN;
    logic [NCH-1:0]          DATA_RE;
    logic                    FIFO_FULL;
    logic [WORD_W:0]         DATA_OUT;
    logic                    DATA_WE;

    modport master (
        output DATA_IN,
        output DATA_RE,
        output FIFO_FULL,
        input  DATA_OUT,
        input  DATA_WE
    );

    modport slave (
        input  DATA_IN,
        input  DATA_RE,
        input  FIFO_FULL,
        output DATA_OUT,
        output DATA_WE
    );
endinterface

// File: rtl/rng_word_packer.sv
// Serial-to-parallel packer: shifts random bits in at the LSB and flags the
// cycle in which the WORD_W-th bit arrives, presenting the full word combinationally.
module rng_word_packer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rnd_bit,
    input  logic              valid,
    input  logic              clear,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

    logic [WORD_W-2:0] shift_reg;
    logic [CNT_W-1:0]  cnt_reg;

    // The completing bit is never stored; it goes straight into the LSB of the output.
    assign word      = {shift_reg, rnd_bit};
    assign word_done = valid && (cnt_reg == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (valid) begin
            if (word_done) begin
                shift_reg <= '0;
                cnt_reg   <= '0;
            end else begin
                shift_reg <= {shift_reg[WORD_W-3:0], rnd_bit};
                cnt_reg   <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_ctrl_mc.sv
// Multi-channel RNG controller: derives one bit per accepted sample event, packs
// words for the FIFO with DMA "last" tagging, byte budget and overflow policy.
module rng_ctrl_mc
    import rng_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int SAMPLE_W = 16,
    parameter int WORD_W   = 32,
    parameter int CW       = 32,
    localparam int CSW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK,
    input  logic              RST_X,
    rng_ctrl_mc_if.slave      bus,
    input  logic              GO,
    input  logic              STOP,
    input  logic              MODE,
    input  logic [CSW-1:0]    CH_SEL,
    input  logic [NCH-1:0]    CH_EN,
    input  logic              OVF_MODE,
    output logic              RUN,
    output logic              OVER,
    output logic [DROP_W-1:0] DROP_CNT,
    input  logic [CW-1:0]     SEND_BYTES,
    output logic [CW-1:0]     SENT_BYTES,
    input  logic [CW-1:0]     DMA_BYTES,
    output logic [CW-1:0]     SUM_DATA
);
    localparam int BPW = bpw(WORD_W);
    localparam logic [CW-1:0] BPW_C   = CW'(BPW);
    localparam logic [CW:0]   BPW_EXT = (CW+1)'(BPW);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    mode_e             mode_reg;
    ovf_e              ovf_reg;
    logic [CSW-1:0]    ch_sel_reg;
    logic [NCH-1:0]    ch_en_reg;
    logic              run_reg;
    logic              over_reg;
    logic [DROP_W-1:0] drop_cnt_reg;
    logic [CW-1:0]     sent_reg;
    logic [CW-1:0]     sum_reg;
    logic [CW-1:0]     dma_cnt_reg;

    logic [SAMPLE_W-1:0] samples [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign samples[gi] = bus.DATA_IN[gi*SAMPLE_W +: SAMPLE_W];
    end

    logic [SAMPLE_W-1:0] sel_sample;
    logic [SAMPLE_W-1:0] xor_sample;
    logic [SAMPLE_W-1:0] src_sample;
    logic                sel_re;
    logic                xor_re;
    logic                src_re;

    always_comb begin
        sel_sample = '0;
        sel_re     = 1'b0;
        if (int'(ch_sel_reg) < NCH) begin
            sel_sample = samples[ch_sel_reg];
            sel_re     = bus.DATA_RE[ch_sel_reg];
        end
        xor_sample = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_en_reg[i]) begin
                xor_sample = xor_sample ^ samples[i];
            end
        end
        // An empty mask must never produce an event, hence the explicit |ch_en_reg.
        xor_re = (|ch_en_reg) && ((bus.DATA_RE & ch_en_reg) == ch_en_reg);
        if (mode_reg == MODE_XOR) begin
            src_sample = xor_sample;
            src_re     = xor_re;
        end else begin
            src_sample = sel_sample;
            src_re     = sel_re;
        end
    end

    logic              accept;
    logic [WORD_W-1:0] word;
    logic              word_done;
    logic              write;
    logic              overflow;
    logic              last;
    logic [CW-1:0]     sent_next;
    logic [CW:0]       dma_sum;

    assign accept = run_reg && !STOP && !GO && src_re;

    rng_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (CLK),
        .rst_n     (RST_X),
        .rnd_bit   (src_sample[0]),
        .valid     (accept),
        .clear     (STOP),
        .word      (word),
        .word_done (word_done)
    );

    assign write     = word_done && !bus.FIFO_FULL;
    assign overflow  = word_done && bus.FIFO_FULL;
    assign sent_next = sent_reg + BPW_C;
    // One extra bit keeps the packet-boundary compare exact near the top of the range.
    assign dma_sum   = {1'b0, dma_cnt_reg} + BPW_EXT;
    assign last      = (dma_sum >= {1'b0, DMA_BYTES});

    assign bus.DATA_WE  = write;
    assign bus.DATA_OUT = write ? {last, word} : '0;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            mode_reg     <= MODE_SINGLE;
            ovf_reg      <= OVF_HALT;
            ch_sel_reg   <= '0;
            ch_en_reg    <= '0;
            run_reg      <= 1'b0;
            over_reg     <= 1'b0;
            drop_cnt_reg <= '0;
            sent_reg     <= '0;
            sum_reg      <= '0;
            dma_cnt_reg  <= '0;
        end else if (STOP) begin
            mode_reg     <= MODE_SINGLE;
            ovf_reg      <= OVF_HALT;
            ch_sel_reg   <= '0;
            ch_en_reg    <= '0;
            run_reg      <= 1'b0;
            over_reg     <= 1'b0;
            drop_cnt_reg <= '0;
            sent_reg     <= '0;
            sum_reg      <= '0;
            dma_cnt_reg  <= '0;
        end else if (GO) begin
            if (!run_reg) begin
                run_reg    <= 1'b1;
                mode_reg   <= mode_e'(MODE);
                ovf_reg    <= ovf_e'(OVF_MODE);
                ch_sel_reg <= CH_SEL;
                ch_en_reg  <= CH_EN;
            end
        end else if (accept) begin
            sum_reg <= sum_reg + CW'(src_sample);
            if (write) begin
                sent_reg    <= sent_next;
                dma_cnt_reg <= last ? '0 : (dma_cnt_reg + BPW_C);
                if ((SEND_BYTES != '0) && (sent_next >= SEND_BYTES)) begin
                    run_reg <= 1'b0;
                end
            end else if (overflow) begin
                over_reg <= 1'b1;
                if (ovf_reg == OVF_HALT) begin
                    run_reg <= 1'b0;
                end else if (drop_cnt_reg != DROP_MAX) begin
                    drop_cnt_reg <= drop_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign RUN        = run_reg;
    assign OVER       = over_reg;
    assign DROP_CNT   = drop_cnt_reg;
    assign SENT_BYTES = sent_reg;
    assign SUM_DATA   = sum_reg;

endmodule

// File: tb/tb_rng_ctrl_mc.sv
// Directed bench for rng_ctrl_mc: stimulus pushes expected FIFO writes into queues,
// a negedge monitor pops and compares every DATA_WE; register outputs checked inline.
module tb_rng_ctrl_mc;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp32_q [$];
    logic [8:0]  exp8_q  [$];

    // 32-bit instance
    rng_ctrl_mc_if #(.NCH(4), .SAMPLE_W(16), .WORD_W(32)) bus32 ();
    logic        go, stop, mode, ovf_mode;
    logic [1:0]  ch_sel;
    logic [3:0]  ch_en;
    logic        run, over;
    logic [15:0] drop_cnt;
    logic [31:0] send_bytes, sent_bytes, dma_bytes, sum_data;

    rng_ctrl_mc #(.NCH(4), .SAMPLE_W(16), .WORD_W(32), .CW(32)) dut32 (
        .CLK(clk), .RST_X(rst_n), .bus(bus32),
        .GO(go), .STOP(stop), .MODE(mode), .CH_SEL(ch_sel), .CH_EN(ch_en),
        .OVF_MODE(ovf_mode), .RUN(run), .OVER(over), .DROP_CNT(drop_cnt),
        .SEND_BYTES(send_bytes), .SENT_BYTES(sent_bytes),
        .DMA_BYTES(dma_bytes), .SUM_DATA(sum_data)
    );

    // 8-bit instance
    rng_ctrl_mc_if #(.NCH(4), .SAMPLE_W(16), .WORD_W(8)) bus8 ();
    logic        go8, stop8, mode8, ovf_mode8;
    logic [1:0]  ch_sel8;
    logic [3:0]  ch_en8;
    logic        run8, over8;
    logic [15:0] drop_cnt8;
    logic [31:0] send_bytes8, sent_bytes8, dma_bytes8, sum_data8;

    rng_ctrl_mc #(.NCH(4), .SAMPLE_W(16), .WORD_W(8), .CW(32)) dut8 (
        .CLK(clk), .RST_X(rst_n), .bus(bus8),
        .GO(go8), .STOP(stop8), .MODE(mode8), .CH_SEL(ch_sel8), .CH_EN(ch_en8),
        .OVF_MODE(ovf_mode8), .RUN(run8), .OVER(over8), .DROP_CNT(drop_cnt8),
        .SEND_BYTES(send_bytes8), .SENT_BYTES(sent_bytes8),
        .DMA_BYTES(dma_bytes8), .SUM_DATA(sum_data8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus32.DATA_WE === 1'b1) begin
            if (exp32_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL write32_unexpected got=%0h required=no_write", bus32.DATA_OUT);
            end else begin
                check("write32", 64'(bus32.DATA_OUT), 64'(exp32_q.pop_front()));
            end
        end
        if (rst_n === 1'b1 && bus8.DATA_WE === 1'b1) begin
            if (exp8_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL write8_unexpected got=%0h required=no_write", bus8.DATA_OUT);
            end else begin
                check("write8", 64'(bus8.DATA_OUT), 64'(exp8_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [3:0] re, input logic [15:0] s0, input logic [15:0] s1,
                        input logic [15:0] s2, input logic [15:0] s3);
        bus32.DATA_IN = {s3, s2, s1, s0};
        bus32.DATA_RE = re;
        tick();
        bus32.DATA_RE = '0;
    endtask

    task automatic feed8(input logic b);
        bus8.DATA_IN = {48'h0, 15'h0, b};
        bus8.DATA_RE = 4'b0001;
        tick();
        bus8.DATA_RE = '0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    logic [31:0] words [4];
    logic [31:0] pat;
    logic [7:0]  pat8;
    logic        b;

    initial begin
        words[0] = 32'h12345678;
        words[1] = 32'hDEADBEEF;
        words[2] = 32'h0F0F00FF;
        words[3] = 32'h80000001;

        rst_n = 1'b0;
        go = 0; stop = 0; mode = 0; ovf_mode = 0; ch_sel = 0; ch_en = 0;
        send_bytes = 0; dma_bytes = 0;
        go8 = 0; stop8 = 0; mode8 = 0; ovf_mode8 = 0; ch_sel8 = 0; ch_en8 = 0;
        send_bytes8 = 0; dma_bytes8 = 0;
        bus32.DATA_IN = '0; bus32.DATA_RE = '0; bus32.FIFO_FULL = 1'b0;
        bus8.DATA_IN  = '0; bus8.DATA_RE  = '0; bus8.FIFO_FULL  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_run", 64'(run), 64'd0);
        check("reset_over", 64'(over), 64'd0);
        check("reset_drop", 64'(drop_cnt), 64'd0);
        check("reset_sent", 64'(sent_bytes), 64'd0);
        check("reset_sum", 64'(sum_data), 64'd0);
        check("reset_we", 64'(bus32.DATA_WE), 64'd0);
        check("reset_out", 64'(bus32.DATA_OUT), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // MODE0 on channel 2, alternating bits
        mode = 0; ch_sel = 2; dma_bytes = 4;
        pulse_go();
        check("t1_run", 64'(run), 64'd1);
        exp32_q.push_back({1'b1, 32'hAAAAAAAA});
        for (int k = 0; k < 32; k++) begin
            b = (k % 2 == 0);
            feed(4'b0100, 16'hFFFF, 16'h0000, 16'h1230 | {15'h0, b}, 16'h5555);
        end
        check("t1_sent", 64'(sent_bytes), 64'd4);
        check("t1_sum", 64'(sum_data), 64'h24610);
        check("t1_run_after", 64'(run), 64'd1);
        pulse_stop();
        check("t1_stop_sent", 64'(sent_bytes), 64'd0);
        check("t1_stop_sum", 64'(sum_data), 64'd0);
        check("t1_stop_run", 64'(run), 64'd0);

        // MODE1 XOR of channels 0 and 2; non-joint events must be ignored
        mode = 1; ch_en = 4'b0101;
        pulse_go();
        mode = 0; ch_sel = 1; ch_en = 4'b1111;
        exp32_q.push_back({1'b1, 32'hFFFFFFFF});
        for (int k = 0; k < 32; k++) begin
            feed(4'b0001, 16'h0000, 16'h0000, 16'h0F00, 16'h0000);
            feed(4'b0101, 16'h00F1, 16'hFFFF, 16'h0F00, 16'h0000);
        end
        check("t2_sent", 64'(sent_bytes), 64'd4);
        check("t2_sum", 64'(sum_data), 64'h1FE20);
        pulse_stop();

        // DMA packets of 8 bytes, budget 16 bytes
        mode = 0; ch_sel = 0; ch_en = 0; dma_bytes = 8; send_bytes = 16;
        pulse_go();
        for (int w = 0; w < 4; w++) begin
            pat = words[w];
            exp32_q.push_back({(w % 2 == 1), pat});
            for (int k = 31; k >= 0; k--) begin
                feed(4'b0001, {15'h0, pat[k]}, 16'h0, 16'h0, 16'h0);
            end
            check("t3_run_after_word", 64'(run), (w < 3) ? 64'd1 : 64'd0);
        end
        for (int k = 0; k < 32; k++) begin
            feed(4'b0001, 16'h0001, 16'h0, 16'h0, 16'h0);
        end
        check("t3_sent", 64'(sent_bytes), 64'd16);
        check("t3_run_idle", 64'(run), 64'd0);
        pulse_stop();
        send_bytes = 0;

        // Overflow with halt policy
        dma_bytes = 4; ovf_mode = 0; bus32.FIFO_FULL = 1'b1;
        pulse_go();
        for (int k = 0; k < 32; k++) begin
            feed(4'b0001, 16'h0001, 16'h0, 16'h0, 16'h0);
        end
        check("t4_over", 64'(over), 64'd1);
        check("t4_run", 64'(run), 64'd0);
        check("t4_sent", 64'(sent_bytes), 64'd0);
        check("t4_drop", 64'(drop_cnt), 64'd0);
        pulse_stop();
        check("t4_stop_over", 64'(over), 64'd0);

        // Overflow with drop policy
        ovf_mode = 1;
        pulse_go();
        for (int k = 0; k < 96; k++) begin
            feed(4'b0001, 16'h0001, 16'h0, 16'h0, 16'h0);
        end
        check("t4_drop3", 64'(drop_cnt), 64'd3);
        check("t4_run_drop", 64'(run), 64'd1);
        check("t4_over_drop", 64'(over), 64'd1);
        bus32.FIFO_FULL = 1'b0;
        exp32_q.push_back({1'b1, 32'h0000FFFF});
        for (int k = 0; k < 32; k++) begin
            feed(4'b0001, (k >= 16) ? 16'h0001 : 16'h0000, 16'h0, 16'h0, 16'h0);
        end
        check("t4_sent_after", 64'(sent_bytes), 64'd4);
        pulse_stop();
        ovf_mode = 0;

        // STOP and GO together mid-word
        mode = 0; ch_sel = 3; dma_bytes = 0;
        pulse_go();
        for (int k = 0; k < 17; k++) begin
            feed(4'b1000, 16'h0, 16'h0, 16'h0, 16'h0001);
        end
        check("t5_sum_mid", 64'(sum_data), 64'd17);
        stop = 1'b1; go = 1'b1;
        tick();
        stop = 1'b0; go = 1'b0;
        check("t5_run", 64'(run), 64'd0);
        check("t5_sum", 64'(sum_data), 64'd0);
        pulse_go();
        pat = 32'hC3A50F96;
        exp32_q.push_back({1'b1, pat});
        for (int k = 31; k >= 0; k--) begin
            feed(4'b1000, 16'h0, 16'h0, 16'h0, {15'h0, pat[k]});
        end
        check("t5_sent", 64'(sent_bytes), 64'd4);
        pulse_stop();

        // Asynchronous reset mid-run
        mode = 0; ch_sel = 0; dma_bytes = 0;
        pulse_go();
        exp32_q.push_back({1'b1, 32'hFFFFFFFF});
        for (int k = 0; k < 37; k++) begin
            feed(4'b0001, 16'h0101, 16'h0, 16'h0, 16'h0);
        end
        check("t6_sent", 64'(sent_bytes), 64'd4);
        check("t6_sum", 64'(sum_data), 64'h2525);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_run", 64'(run), 64'd0);
        check("t6_rst_sent", 64'(sent_bytes), 64'd0);
        check("t6_rst_sum", 64'(sum_data), 64'd0);
        check("t6_rst_we", 64'(bus32.DATA_WE), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 8-bit instance: one byte per word
        mode8 = 0; ch_sel8 = 0; dma_bytes8 = 1;
        go8 = 1'b1;
        tick();
        go8 = 1'b0;
        pat8 = 8'hA5;
        exp8_q.push_back({1'b1, pat8});
        for (int k = 7; k >= 0; k--) feed8(pat8[k]);
        check("t7_sent1", 64'(sent_bytes8), 64'd1);
        pat8 = 8'h3C;
        exp8_q.push_back({1'b1, pat8});
        for (int k = 7; k >= 0; k--) feed8(pat8[k]);
        check("t7_sent2", 64'(sent_bytes8), 64'd2);

        repeat (3) tick();
        check("pending32", 64'(exp32_q.size()), 64'd0);
        check("pending8", 64'(exp8_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rng_ctrl_mc.md
Name: rng_ctrl_mc

Overview:
- Multi-channel, width-parametrised successor of the TRNG controller.
- Collects raw samples from NCH RNG units and derives one random bit per accepted sample event, either single-channel or XOR-combined.
- Packs bits into WORD_W-bit words, pushes them to the output FIFO with a DMA-packet "last" tag, and enforces a byte budget.
- Tracks overflow with a selectable halt-or-drop policy; sits between the RNG units and the FIFO/AXI control register bank.

Parameters:
- NCH, 4, number of RNG input channels (1..16).
- SAMPLE_W, 16, width of each channel's raw sample.
- WORD_W, 32, packed output word width; multiple of 8, 8..64.
- CW, 32, width of byte counters and sum.

Ports:
- CLK  in  1  clock.
- RST_X  in  1  reset, asynchronous, active-low.
- DATA_IN  in  NCH*SAMPLE_W  raw samples; channel i occupies bits [i*SAMPLE_W +: SAMPLE_W].
- DATA_RE  in  NCH  per-channel sample-valid strobe.
- DATA_OUT  out  WORD_W+1  {last, word}; meaningful only while DATA_WE=1.
- DATA_WE  out  1  FIFO write strobe.
- FIFO_FULL  in  1  FIFO cannot accept a write this cycle.
- GO  in  1  start/resume pulse.
- STOP  in  1  abort and clear pulse.
- MODE  in  1  0 = single channel CH_SEL; 1 = XOR of enabled channels.
- CH_SEL  in  $clog2(NCH) (min 1)  source channel for MODE 0.
- CH_EN  in  NCH  channel enable mask for MODE 1.
- OVF_MODE  in  1  0 = halt on overflow; 1 = drop word and continue.
- RUN  out  1  controller active.
- OVER  out  1  sticky overflow flag.
- DROP_CNT  out  16  words dropped; saturates at 16'hFFFF.
- SEND_BYTES  in  CW  byte budget; 0 = unlimited.
- SENT_BYTES  out  CW  bytes written to the FIFO.
- DMA_BYTES  in  CW  DMA packet size in bytes.
- SUM_DATA  out  CW  running sum of accepted samples, wraps mod 2^CW.

Behaviour:
- Reset (async, RST_X=0): RUN=0, OVER=0, DROP_CNT=0, SENT_BYTES=0, SUM_DATA=0, DATA_WE=0, DATA_OUT=0. Internal bit count, shift register, DMA byte count and latched configuration are all cleared. Reset mid-word discards the partial word.
- Priority each cycle: STOP > GO > data.
- STOP: same clearing as reset (synchronous), except configuration latches are cleared too.
- GO with RUN=0: RUN=1 next cycle. MODE, CH_SEL, CH_EN and OVF_MODE are latched at GO; later changes are ignored until the next GO.
- GO with RUN=1: no effect. Counters and any partial word persist across halt/GO; only STOP clears them.
- Accept event (RUN=1, no STOP/GO):
  - MODE 0: DATA_RE[CH_SEL]=1.
  - MODE 1: every channel with CH_EN=1 has DATA_RE=1; CH_EN=0 means no events ever.
  - Bit = DATA_IN[CH_SEL][0] in MODE 0, or XOR of bit 0 over enabled channels in MODE 1.
  - SUM_DATA += the selected sample (MODE 0) or the bitwise XOR of enabled samples (MODE 1), zero-extended.
- Packing: shift left, new bit enters the LSB. On the WORD_W-th bit the word is {previous WORD_W-1 bits, new bit}.
- DATA_WE is combinational in the same cycle as the completing accept event when FIFO_FULL=0. Zero latency; the bit count returns to 0.
- Word completion with FIFO_FULL=0:
  - SENT_BYTES += BPW, where BPW = WORD_W/8.
  - last=1 when dma_cnt+BPW >= DMA_BYTES; then dma_cnt←0, else dma_cnt += BPW. DMA_BYTES=0 tags every word last.
  - RUN←0 when SEND_BYTES≠0 and new SENT_BYTES >= SEND_BYTES.
- Word completion with FIFO_FULL=1: no write and the word is discarded; OVER←1 (sticky until STOP/reset).
  - OVF_MODE 0: RUN←0.
  - OVF_MODE 1: DROP_CNT++ (saturating), RUN unchanged.
- Counters wrap mod 2^CW except DROP_CNT. SEND_BYTES not a multiple of BPW rounds up (stop at the first word reaching or exceeding it).

Decomposition:
- Package rng_pkg: mode enum (MODE_SINGLE, MODE_XOR), ovf enum (OVF_HALT, OVF_DROP), localparam function bpw(WORD_W).
- Sub-module rng_word_packer (params WORD_W): shift register plus bit counter. Inputs: bit, valid, clear. Outputs: word, word_done.

Test Plan:
- MODE0, CH_SEL=2, WORD_W=32, GO, then 32 events with bit pattern 1,0,1,0,... -> exactly one DATA_WE with word=32'hAAAAAAAA, SENT_BYTES=4.
- MODE1, CH_EN=4'b0101, ch0 bits all 1, ch2 bits all 0, ch1 RE held low -> 32 joint events produce word 32'hFFFFFFFF. Events with ch2 RE low are not accepted.
- DMA_BYTES=8, SEND_BYTES=16 -> 4 words with last = 0,1,0,1; RUN drops the cycle after the 4th write; further RE ignored.
- FIFO_FULL held high on completion with OVF_MODE=0 -> no DATA_WE, OVER=1, RUN=0. Repeat with OVF_MODE=1 over 3 words -> DROP_CNT=3, RUN=1.
- STOP and GO in the same cycle mid-word (bit count 17) -> everything cleared, RUN=0. A following GO packs a fresh 32 bits.
- RST_X asserted asynchronously mid-run -> all outputs zero immediately. WORD_W=8 instance gives SENT_BYTES +1 per 8 bits.
